// File: rtl/fetch_mem_sequencer_pkg.sv
// Shared encodings for the fetch/memory sequencer: FSM states, micro-ops,
// condition codes and the condition evaluator.
package fetch_mem_sequencer_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_FETCH  = 3'd0;
    localparam state_t ST_WAIT_I = 3'd1;
    localparam state_t ST_DECODE = 3'd2;
    localparam state_t ST_EXEC   = 3'd3;
    localparam state_t ST_DATA   = 3'd4;
    localparam state_t ST_WAIT_D = 3'd5;
    localparam state_t ST_HALT   = 3'd6;

    localparam logic [4:0] UOP_NOP    = 5'h00;
    localparam logic [4:0] UOP_ALU    = 5'h01;
    localparam logic [4:0] UOP_BRANCH = 5'h02;
    localparam logic [4:0] UOP_LDR    = 5'h10;
    localparam logic [4:0] UOP_STR    = 5'h11;

    localparam logic [3:0] COND_EQ   = 4'b0000;
    localparam logic [3:0] COND_NE   = 4'b0001;
    localparam logic [3:0] COND_HI   = 4'b1000;
    localparam logic [3:0] COND_LS   = 4'b1001;
    localparam logic [3:0] COND_GT   = 4'b1100;
    localparam logic [3:0] COND_LE   = 4'b1101;
    localparam logic [3:0] COND_AL   = 4'b1110;
    localparam logic [3:0] COND_NONE = 4'b1111;

    // flags are packed {N,Z,C,V}; COND_NONE never passes.
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] flags);
        logic n, z, c, v;
        {n, z, c, v} = flags;
        case (cond)
            4'h0:    return z;
            4'h1:    return !z;
            4'h2:    return c;
            4'h3:    return !c;
            4'h4:    return n;
            4'h5:    return !n;
            4'h6:    return v;
            4'h7:    return !v;
            4'h8:    return c && !z;
            4'h9:    return !c || z;
            4'hA:    return n == v;
            4'hB:    return n != v;
            4'hC:    return !z && (n == v);
            4'hD:    return z || (n != v);
            4'hE:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/fetch_mem_sequencer_cond_check.sv
// Combinational branch-condition check against the ALU flags.
module fetch_mem_sequencer_cond_check
    import fetch_mem_sequencer_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] flags_i,
    output logic       taken_o
);
    assign taken_o = cond_pass(cond_i, flags_i);
endmodule

// File: rtl/fetch_mem_sequencer.sv
// Fetch/decode/execute sequencer sharing one memory port between instruction
// fetch and LDR/STR. Optional ack watchdog: define FETCH_WATCHDOG_EN.
module fetch_mem_sequencer
    import fetch_mem_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          ACK_TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [4:0]  uop_i,
    input  logic [3:0]  branch_cond_i,
    input  logic [31:0] num_i,
    input  logic [3:0]  flags_i,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i,
    output logic [15:0] instr_out_o,
    output logic        instr_valid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_done_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [31:0] pc_o,
    output logic        bus_error_o
);
    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic [31:0] rdata_q, rdata_d;
    logic        done_q, done_d;
    logic        dwe_q, dwe_d;
    logic [31:0] daddr_q, daddr_d;
    logic [31:0] dwdata_q, dwdata_d;
    logic        taken, is_mem_uop, wd_expire, data_phase, req_phase;

    fetch_mem_sequencer_cond_check u_cond (
        .cond_i  (branch_cond_i),
        .flags_i (flags_i),
        .taken_o (taken)
    );

    assign is_mem_uop = (uop_i == UOP_LDR) || (uop_i == UOP_STR);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        rdata_d  = rdata_q;
        done_d   = 1'b0;
        dwe_d    = dwe_q;
        daddr_d  = daddr_q;
        dwdata_d = dwdata_q;
        case (state_q)
            ST_FETCH:  state_d = ST_WAIT_I;
            ST_WAIT_I: begin
                if (mem_ack_i) begin
                    instr_d = pc_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
                    state_d = ST_DECODE;
                end else if (wd_expire) begin
                    state_d = ST_HALT;
                end
            end
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC: begin
                // Data operands are captured here so the bus stays stable until ack.
                if (is_mem_uop && data_req_i) begin
                    dwe_d    = data_we_i;
                    daddr_d  = data_addr_i;
                    dwdata_d = data_wdata_i;
                    state_d  = ST_DATA;
                end else begin
                    pc_d    = taken ? pc_q + 32'd4 + (num_i << 1) : pc_q + 32'd2;
                    state_d = ST_FETCH;
                end
            end
            ST_DATA:   state_d = ST_WAIT_D;
            ST_WAIT_D: begin
                if (mem_ack_i) begin
                    if (!dwe_q) rdata_d = mem_rdata_i;
                    done_d  = 1'b1;
                    pc_d    = pc_q + 32'd2;
                    state_d = ST_FETCH;
                end else if (wd_expire) begin
                    state_d = ST_HALT;
                end
            end
            default:   state_d = state_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_FETCH;
            pc_q     <= {RESET_PC[31:1], 1'b0};
            instr_q  <= '0;
            rdata_q  <= '0;
            done_q   <= 1'b0;
            dwe_q    <= 1'b0;
            daddr_q  <= '0;
            dwdata_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            rdata_q  <= rdata_d;
            done_q   <= done_d;
            dwe_q    <= dwe_d;
            daddr_q  <= daddr_d;
            dwdata_q <= dwdata_d;
        end
    end

`ifdef FETCH_WATCHDOG_EN
    localparam int WD_W = ($clog2(ACK_TIMEOUT + 1) < 8) ? 8 : $clog2(ACK_TIMEOUT + 1);
    logic [WD_W-1:0] wd_cnt_q;
    logic            bus_err_q;
    logic            in_wait;

    assign in_wait   = (state_q == ST_WAIT_I) || (state_q == ST_WAIT_D);
    assign wd_expire = in_wait && !mem_ack_i && (wd_cnt_q == WD_W'(ACK_TIMEOUT - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wd_cnt_q  <= '0;
            bus_err_q <= 1'b0;
        end else begin
            wd_cnt_q <= (in_wait && !mem_ack_i) ? wd_cnt_q + 1'b1 : '0;
            if (wd_expire) bus_err_q <= 1'b1;
        end
    end
    assign bus_error_o = bus_err_q;
`else
    logic unused_ack_timeout;
    assign unused_ack_timeout = (ACK_TIMEOUT != 0);
    assign wd_expire          = 1'b0;
    assign bus_error_o        = 1'b0;
`endif

    // Reset gates the request combinationally so an access dies the moment reset asserts.
    assign data_phase    = (state_q == ST_DATA) || (state_q == ST_WAIT_D);
    assign req_phase     = (state_q == ST_FETCH) || (state_q == ST_WAIT_I) || data_phase;
    assign mem_req_o     = rst_ni && req_phase;
    assign mem_we_o      = mem_req_o && data_phase && dwe_q;
    assign mem_addr_o    = !mem_req_o ? '0 : (data_phase ? daddr_q : {pc_q[31:2], 2'b00});
    assign mem_wdata_o   = (mem_req_o && data_phase) ? dwdata_q : '0;
    assign instr_out_o   = instr_q;
    assign instr_valid_o = (state_q == ST_DECODE);
    assign data_rdata_o  = rdata_q;
    assign data_done_o   = done_q;
    assign pc_o          = pc_q;

endmodule

// File: tb/tb_fetch_mem_sequencer.sv
// Directed bench for fetch_mem_sequencer with a scoreboard of expected memory accesses.
module tb_fetch_mem_sequencer;
    import fetch_mem_sequencer_pkg::*;

    logic        clk, rst_n;
    logic [4:0]  uop;
    logic [3:0]  cond, flags;
    logic [31:0] num, data_addr, data_wdata, mem_rdata;
    logic        data_req, data_we, mem_ack;
    logic [15:0] instr_out;
    logic        instr_valid, data_done, mem_req, mem_we, bus_error;
    logic [31:0] data_rdata, mem_addr, mem_wdata, pc;

    fetch_mem_sequencer #(.RESET_PC(32'h0), .ACK_TIMEOUT(8)) dut (
        .clk_i(clk), .rst_ni(rst_n), .uop_i(uop), .branch_cond_i(cond), .num_i(num),
        .flags_i(flags), .data_req_i(data_req), .data_we_i(data_we), .data_addr_i(data_addr),
        .data_wdata_i(data_wdata), .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack),
        .instr_out_o(instr_out), .instr_valid_o(instr_valid), .data_rdata_o(data_rdata),
        .data_done_o(data_done), .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .pc_o(pc), .bus_error_o(bus_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic we; logic [31:0] wdata; } acc_t;
    typedef struct {
        logic [31:0] word; int waitc; logic early;
        logic [4:0] uop; logic [3:0] cond; logic [3:0] flg; logic [31:0] num; logic dreq; logic taken;
    } step_t;

    acc_t        acc_q[$];
    logic [15:0] ins_q[$];
    step_t       steps[$];
    logic [31:0] m_pc, m_rdata;
    int          checks = 0, errors = 0;

    task automatic nedge();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_fetch();
        acc_t a;
        a.addr = {m_pc[31:2], 2'b00}; a.we = 1'b0; a.wdata = 32'h0;
        acc_q.push_back(a);
    endtask

    task automatic chk_acc(input string tag);
        acc_t e;
        if (acc_q.size() == 0) begin
            checks++; errors++;
            $error("FAIL %s: observed request with empty scoreboard, expected none", tag);
            return;
        end
        e = acc_q.pop_front();
        chk({tag, ".req"}, mem_req, 1);
        chk({tag, ".addr"}, mem_addr, e.addr);
        chk({tag, ".we"}, mem_we, e.we);
        if (e.we) chk({tag, ".wdata"}, mem_wdata, e.wdata);
    endtask

    // Entered at the FETCH cycle; leaves in DECODE.
    task automatic fetch(input logic [31:0] word, input int waitc, input logic early);
        logic [15:0] e;
        ins_q.push_back(m_pc[1] ? word[31:16] : word[15:0]);
        chk_acc("fetch");
        if (early) begin mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0; end
        nedge();
        chk("done.pulse", data_done, 0);
        mem_ack = 1'b0;
        for (int i = 0; i < waitc; i++) begin
            chk("wait_i.req", mem_req, 1);
            chk("wait_i.valid", instr_valid, 0);
            nedge();
        end
        mem_ack = 1'b1; mem_rdata = word;
        nedge();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        chk("decode.valid", instr_valid, 1);
        chk("decode.req", mem_req, 0);
        e = ins_q.pop_front();
        chk("decode.instr", instr_out, e);
    endtask

    // Entered in DECODE; leaves in the next FETCH.
    task automatic exec_step(input step_t s);
        nedge();
        chk("exec.valid", instr_valid, 0);
        uop = s.uop; cond = s.cond; flags = s.flg; num = s.num; data_req = s.dreq;
        m_pc = s.taken ? m_pc + 32'd4 + (s.num << 1) : m_pc + 32'd2;
        push_fetch();
        nedge();
        uop = UOP_NOP; cond = COND_NONE; flags = 4'h0; num = 32'h0; data_req = 1'b0;
        chk("exec.pc", pc, m_pc);
    endtask

    // Entered in DECODE; LDR/STR through DATA/WAIT_D, optional reset while waiting.
    task automatic mem_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int waitc, input logic rst_mid);
        acc_t a;
        nedge();
        uop = we ? UOP_STR : UOP_LDR; data_req = 1'b1; data_we = we;
        data_addr = addr; data_wdata = wdata; cond = COND_AL; num = 32'd5;
        a.addr = addr; a.we = we; a.wdata = wdata;
        acc_q.push_back(a);
        nedge();
        uop = UOP_NOP; data_req = 1'b0; cond = COND_NONE; num = 32'h0;
        data_addr = 32'hFFFF_FFF0; data_wdata = ~wdata; data_we = ~we;
        chk_acc("data");
        chk("data.done", data_done, 0);
        nedge();
        for (int i = 0; i < waitc; i++) begin
            chk("wait_d.addr", mem_addr, addr);
            chk("wait_d.we", mem_we, we);
            chk("wait_d.wdata", mem_wdata, we ? wdata : 32'h0);
            nedge();
        end
        data_we = 1'b0; data_addr = 32'h0; data_wdata = 32'h0;
        if (rst_mid) begin
            rst_n = 1'b0;
            #1;
            chk("rst.req", mem_req, 0);
            chk("rst.we", mem_we, 0);
            chk("rst.pc", pc, 32'h0);
            chk("rst.rdata", data_rdata, 0);
            m_pc = 32'h0; m_rdata = 32'h0;
            mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
            nedge();
            rst_n = 1'b1;
            #1;
            push_fetch();
        end else begin
            mem_ack = 1'b1; mem_rdata = rdata;
            nedge();
            mem_ack = 1'b0; mem_rdata = 32'h0;
            if (!we) m_rdata = rdata;
            m_pc = m_pc + 32'd2;
            push_fetch();
            chk("data.done_pulse", data_done, 1);
            chk("data.rdata", data_rdata, m_rdata);
            chk("data.pc", pc, m_pc);
        end
    endtask

    initial begin
        rst_n = 1'b0; uop = UOP_NOP; cond = COND_NONE; flags = 4'h0; num = 32'h0;
        data_req = 1'b0; data_we = 1'b0; data_addr = 32'h0; data_wdata = 32'h0;
        mem_rdata = 32'h0; mem_ack = 1'b0; m_rdata = 32'h0;
        repeat (3) nedge();
        chk("reset.req", mem_req, 0);
        chk("reset.addr", mem_addr, 0);
        chk("reset.we", mem_we, 0);
        chk("reset.pc", pc, 0);
        chk("reset.valid", instr_valid, 0);
        chk("reset.done", data_done, 0);
        chk("reset.instr", instr_out, 0);
        chk("reset.bus_error", bus_error, 0);
        rst_n = 1'b1;
        #1;
        m_pc = 32'h0;
        push_fetch();

        //             word          wait early uop         cond       flags num           dreq taken
        steps.push_back('{32'hB0B1_A0A1, 0, 1'b0, UOP_NOP,    COND_NONE, 4'h0, 32'h0,        1'b0, 1'b0}); // -> 2
        steps.push_back('{32'hB0B1_A0A1, 0, 1'b1, UOP_ALU,    COND_NONE, 4'hF, 32'h7,        1'b0, 1'b0}); // -> 4
        steps.push_back('{32'h2222_1111, 2, 1'b0, UOP_NOP,    COND_NONE, 4'h0, 32'h0,        1'b0, 1'b0}); // -> 6
        steps.push_back('{32'h2222_1111, 0, 1'b0, UOP_ALU,    COND_NONE, 4'h0, 32'h0,        1'b0, 1'b0}); // -> 8
        steps.push_back('{32'h3333_4444, 0, 1'b0, UOP_BRANCH, COND_AL,   4'h0, 32'h2,        1'b0, 1'b1}); // -> 10
        steps.push_back('{32'h5555_6666, 1, 1'b0, UOP_BRANCH, COND_AL,   4'h0, 32'hFFFF_FFFE,1'b0, 1'b1}); // -> 10
        steps.push_back('{32'h5555_6666, 0, 1'b0, UOP_BRANCH, COND_EQ,   4'h0, 32'h3,        1'b0, 1'b0}); // -> 12
        steps.push_back('{32'h7777_8888, 0, 1'b0, UOP_BRANCH, COND_EQ,   4'h4, 32'h3,        1'b0, 1'b1}); // -> 1C
        steps.push_back('{32'h9999_AAAA, 0, 1'b0, UOP_BRANCH, COND_NE,   4'h0, 32'h1,        1'b0, 1'b1}); // -> 22
        steps.push_back('{32'hCCCC_BBBB, 0, 1'b0, UOP_BRANCH, COND_GT,   4'h8, 32'h4,        1'b0, 1'b0}); // -> 24
        steps.push_back('{32'hDDDD_EEEE, 0, 1'b0, UOP_BRANCH, COND_LE,   4'h8, 32'h0,        1'b0, 1'b1}); // -> 28
        steps.push_back('{32'h1234_5678, 0, 1'b0, UOP_BRANCH, COND_HI,   4'h2, 32'hFFFF_FFFE,1'b0, 1'b1}); // -> 28
        steps.push_back('{32'h1234_5678, 0, 1'b0, UOP_BRANCH, COND_LS,   4'h2, 32'h8,        1'b0, 1'b0}); // -> 2A
        steps.push_back('{32'hF00D_0F0F, 0, 1'b0, UOP_LDR,    COND_NONE, 4'h0, 32'h0,        1'b0, 1'b0}); // -> 2C
        foreach (steps[i]) begin
            fetch(steps[i].word, steps[i].waitc, steps[i].early);
            exec_step(steps[i]);
        end

        fetch(32'h0000_6801, 0, 1'b0);
        mem_op(1'b0, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 0, 1'b0);   // LDR -> 2E
        fetch(32'h6002_0000, 0, 1'b0);
        mem_op(1'b1, 32'h0000_0080, 32'h0000_1234, 32'hCAFE_F00D, 2, 1'b0); // STR -> 30
        fetch(32'h0000_6003, 0, 1'b0);
        mem_op(1'b1, 32'h0000_0090, 32'h0000_5678, 32'h0, 1, 1'b1);   // STR, reset mid-wait

        fetch(32'hE7FC_E7FC, 0, 1'b1);
        exec_step('{32'h0, 0, 1'b0, UOP_BRANCH, COND_AL, 4'h0, 32'hFFFF_FFFC, 1'b0, 1'b1}); // -> FFFFFFFC
        fetch(32'hABCD_0123, 0, 1'b0);
        exec_step('{32'h0, 0, 1'b0, UOP_NOP, COND_NONE, 4'h0, 32'h0, 1'b0, 1'b0});          // -> FFFFFFFE
        fetch(32'hABCD_0123, 0, 1'b0);
        exec_step('{32'h0, 0, 1'b0, UOP_NOP, COND_NONE, 4'h0, 32'h0, 1'b0, 1'b0});          // wraps -> 0

        chk_acc("stall.fetch");
`ifdef FETCH_WATCHDOG_EN
        for (int i = 1; i <= 8; i++) begin
            nedge();
            chk("wd.req", mem_req, 1);
            chk("wd.err", bus_error, 0);
        end
        nedge();
        chk("wd.err_set", bus_error, 1);
        chk("wd.req_drop", mem_req, 0);
        mem_ack = 1'b1;
        repeat (4) nedge();
        mem_ack = 1'b0;
        chk("wd.halt_req", mem_req, 0);
        chk("wd.halt_err", bus_error, 1);
        chk("wd.halt_valid", instr_valid, 0);
`else
        repeat (20) nedge();
        chk("stall.req", mem_req, 1);
        chk("stall.err", bus_error, 0);
        mem_ack = 1'b1; mem_rdata = 32'h0000_5A5A;
        nedge();
        mem_ack = 1'b0;
        chk("stall.valid", instr_valid, 1);
        chk("stall.instr", instr_out, 32'h5A5A);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_mem_sequencer.md
Name: fetch_mem_sequencer

Overview:
- Posedge-clocked sequencer that owns the program counter and runs fetch -> decode -> execute for the Thumb-subset core.
- Arbitrates one shared 32-bit memory port between instruction fetch and execute-stage LDR/STR traffic.
- Resolves branches from the decoder's branch_cond/num outputs and the ALU flags.
- Sits between instruction/data memory, the negedge decoder and the execute stage.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bit 0 ignored.
- ACK_TIMEOUT, 255, cycles without mem_ack before a bus error; used only with the watchdog.

Ports:
- clk  in  1  core clock; all state on posedge.
- reset  in  1  asynchronous, active-low; state clears while low.
- uop  in  5  decoder micro-op (package encoding).
- branch_cond  in  4  4'b1111 = no branch, 4'b1110 = always, otherwise ARM condition code.
- num  in  32  sign-extended branch offset, in halfwords.
- flags  in  4  {N,Z,C,V} from the ALU.
- data_req  in  1  execute requests a data access (LDR/STR).
- data_we  in  1  1 = store.
- data_addr  in  32  word-aligned data address.
- data_wdata  in  32  store data.
- mem_rdata  in  32  memory read data, valid with mem_ack.
- mem_ack  in  1  memory completion strobe.
- instr_out  out  16  halfword fed to the decoder.
- instr_valid  out  1  one-cycle pulse, instr_out is new.
- data_rdata  out  32  load result.
- data_done  out  1  one-cycle pulse, data access finished.
- mem_req  out  1  memory request, held until ack.
- mem_we  out  1  write enable.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- pc  out  32  address of the current instruction.
- bus_error  out  1  sticky watchdog error; tied 0 without the watchdog.

Behaviour:
- Reset values: pc=RESET_PC, state=FETCH, every other output 0.
- States and transitions:
  - FETCH: mem_req=1, mem_we=0, mem_addr={pc[31:2],2'b00}. Go to WAIT_I.
  - WAIT_I: hold the request. On mem_ack: instr_out = pc[1] ? mem_rdata[31:16] : mem_rdata[15:0]; drop mem_req; go to DECODE.
  - DECODE: instr_valid=1 for exactly this cycle. The decoder latches on the following negedge. Go to EXEC.
  - EXEC: sample uop, branch_cond, num, flags, data_req.
    - If uop is LDR/STR and data_req=1: go to DATA.
    - Otherwise update pc and go to FETCH.
  - DATA: mem_req=1, mem_we=data_we, mem_addr=data_addr, mem_wdata=data_wdata. Go to WAIT_D.
  - WAIT_D: hold the request. On mem_ack: data_rdata=mem_rdata (loads only, otherwise unchanged); data_done=1 for one cycle; pc+=2; go to FETCH.
- PC update in EXEC:
  - Branch taken: pc = pc + 4 + (num << 1), 32-bit wrap.
  - Otherwise, including branch_cond=4'b1111: pc = pc + 2.
- Conditions:
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
  - AL always.
- Memory handshake:
  - mem_ack is ignored in FETCH/DECODE/EXEC/DATA; the earliest usable ack is the cycle after the request is raised.
  - Address and data are stable while mem_req=1.
- Fixed minimum latency per instruction: 4 cycles (non-memory), 6 cycles (LDR/STR), each plus memory wait cycles.
- Boundaries:
  - PC wraps at 2^32.
  - A branch to pc[1]=1 selects the upper halfword.
  - LDR/STR with data_req=0 in EXEC is treated as a non-memory instruction.
  - Reset asserted mid-access drops mem_req immediately; a late ack after release is ignored.

Optional Feature:
- Macro FETCH_WATCHDOG_EN.
- Defined:
  - An 8+ bit counter runs in WAIT_I/WAIT_D.
  - After ACK_TIMEOUT cycles without ack: set bus_error (sticky until reset), drop mem_req, enter HALT.
  - HALT is terminal until reset.
- Undefined: no counter, no HALT state, bus_error tied 0, the sequencer waits forever.

Decomposition:
- Shared package Utilities gains:
  - the state enum (FETCH, WAIT_I, DECODE, EXEC, DATA, WAIT_D, HALT);
  - condition-code constants (COND_AL=4'b1110, COND_NONE=4'b1111);
  - the cond_pass(cond, flags) function.
- uop constants are reused from Utilities.
- One sub-module is natural: cond_check, combinational, taking cond/flags and returning taken.

Test Plan:
- Reset release, RESET_PC=0, ack one cycle after each req -> mem_addr sequence 0,0,4,4; instr_out lower then upper halfword; pc=2 after the first EXEC.
- EXEC with branch_cond=4'b1110, num=32'hFFFF_FFFE, pc=0x10 -> pc=0x10 (loop to self); next mem_addr=0x10.
- branch_cond=EQ (0000), flags Z=0 -> pc+2. Z=1, num=3 -> pc+10.
- uop=LDR, data_req=1, data_addr=0x40, mem_rdata=0xDEADBEEF -> mem_we=0 at 0x40, data_rdata=0xDEADBEEF, data_done pulses once, then fetch at pc+2.
- uop=STR, data_we=1, data_wdata=0x1234 -> mem_we=1, mem_wdata=0x1234 held until ack; reset pulse mid-WAIT_D -> mem_req=0 at once, pc=RESET_PC.
- With FETCH_WATCHDOG_EN, ACK_TIMEOUT=8, no ack -> bus_error=1 after 8 cycles, mem_req=0, no further requests until reset.
